led_status_sequencer: RTL
=========================

Name: led_status_sequencer

Overview:
- Controller that shares the single board status LED between NUM_REQ status requesters, e.g. logging active, USB attached and error.
- Fixed-priority, non-preemptive arbitration. The winner's blink code (N on-pulses followed by a gap) is sequenced on o_led.
- Includes its own tick prescaler so all timing is in ticks.
- Sits between the logger control FSMs and the LED pin, replacing free-running blink logic.

Parameters:
NUM_REQ, 4, number of requesters; index 0 has the highest priority
COUNT_W, 4, width of each blink-code field (max 15 pulses)
TICK_DIV, 16000, i_clk cycles per tick (1 ms at 16 MHz); must be >= 2
ON_TICKS, 150, LED-on ticks per pulse; must be >= 1
OFF_TICKS, 150, LED-off ticks between pulses; must be >= 1
GAP_TICKS, 1000, LED-off ticks after the last pulse; must be >= 1
PHASE_W, 16, width of the phase tick counter

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_enable  input  1  global enable; low forces LED off and the FSM to IDLE
i_req  input  NUM_REQ  level request per requester
i_code  input  NUM_REQ*COUNT_W  pulse count per requester; field k is bits [k*COUNT_W +: COUNT_W]
o_led  output  1  LED drive, registered
o_grant  output  NUM_REQ  one-hot grant, registered; all zeros when idle
o_busy  output  1  high in any state except IDLE
o_done  output  1  one-cycle pulse on completion of a full sequence

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_led=0, o_grant=0, o_busy=0, o_done=0, tick and phase counters=0.
- Tick generator:
  - Counts 0..TICK_DIV-1 and asserts internal tick on count TICK_DIV-1, then wraps to 0.
  - Cleared to 0 on every IDLE->ON transition, so phases are cycle-exact.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - Eligible requesters have i_req[k]=1 and i_code field k != 0. A zero code is never granted.
  - If i_enable=1 and any requester is eligible, grant the lowest eligible index.
  - On that edge: latch the code into the pulse counter, set o_grant one-hot, o_led=1, go to ON.
  - Request seen at edge t gives o_grant and o_led high after edge t (1-cycle latency).
- ON: o_led=1. After ON_TICKS ticks, decrement the pulse counter; if the result is 0 go to GAP, else go to OFF. o_led=0 from that edge.
- OFF: o_led=0. After OFF_TICKS ticks go to ON with o_led=1.
- GAP: o_led=0. After GAP_TICKS ticks: o_done=1 for that one cycle, o_grant=0, go to IDLE.
- Timing and arbitration:
  - Phase counter resets on every state entry and increments on tick; the state exits on the tick where the count reaches N-1.
  - Each phase therefore lasts exactly N*TICK_DIV cycles.
  - Every sequence spends at least 1 cycle in IDLE before re-arbitration. A persistent request repeats its code back-to-back, separated by GAP plus 1 cycle.
  - Non-preemptive: a higher-priority request arriving mid-sequence waits for IDLE.
  - Code changes on the granted requester are ignored after the latch.
- Abort, in any non-IDLE state:
  - Granted i_req drops: go to GAP immediately (o_led=0 next edge, keep o_grant), finish GAP, then pulse o_done.
  - i_enable drops: next edge state=IDLE, o_led=0, o_grant=0, no o_done. Takes precedence over a simultaneous phase end or request drop.
- Reset mid-sequence: outputs return to reset values asynchronously.

Test Plan (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3, NUM_REQ=4, COUNT_W=4):
- Reset, then i_enable=1, i_req=4'b0100, code[2]=2 at edge 0:
  - o_grant=4'b0100 and o_busy=1 after edge 0.
  - o_led high 8 cycles, low 4, high 8, low 12.
  - o_done pulse on cycle 32; o_grant=0 after it.
- i_req=4'b1010 with codes 1 and 3 simultaneously: index 1 granted. After its done and 1 IDLE cycle, index 3 is granted if still requesting.
- Index 3 sequence running (code 3), raise i_req[0] with code 1 at cycle 5: no preemption, o_grant stays 4'b1000 to done, then 4'b0001.
- Code 0 with i_req=1: no grant, o_busy=0, o_led=0 indefinitely. Code 15: exactly 15 on-pulses counted.
- Drop the granted i_req during the 2nd ON: o_led=0 next edge, 12 GAP cycles, then o_done.
  - Repeat with an i_enable drop instead: IDLE next edge, o_grant=0, no o_done.
- Assert i_rst_n=0 mid-OFF: o_led, o_grant, o_busy go 0 without a clock edge. After release, the sequence restarts cleanly from IDLE.

Source files
------------

// File: rtl/led_status_sequencer.sv
// Shares one status LED between NUM_REQ requesters: fixed-priority, non-preemptive
// arbitration, then the winner's blink code (N pulses + gap) is played on o_led.
module led_status_sequencer #(
    parameter int NUM_REQ   = 4,
    parameter int COUNT_W   = 4,
    parameter int TICK_DIV  = 16000,
    parameter int ON_TICKS  = 150,
    parameter int OFF_TICKS = 150,
    parameter int GAP_TICKS = 1000,
    parameter int PHASE_W   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_enable,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*COUNT_W-1:0]   i_code,
    output logic                         o_led,
    output logic [NUM_REQ-1:0]           o_grant,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_GAP} state_t;

    state_t               state_q, state_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]        tick_q;
    logic [PHASE_W-1:0]   phase_q;
    logic                 led_q, led_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 done_q, done_d;

    logic                 tick, on_end, off_end, gap_end, req_held;
    logic [NUM_REQ-1:0]   elig, pick_oh;
    logic [COUNT_W-1:0]   pick_code;

    assign tick     = (tick_q == TW'(TICK_DIV - 1));
    assign on_end   = tick && (phase_q == PHASE_W'(ON_TICKS - 1));
    assign off_end  = tick && (phase_q == PHASE_W'(OFF_TICKS - 1));
    assign gap_end  = tick && (phase_q == PHASE_W'(GAP_TICKS - 1));
    assign req_held = |(i_req & grant_q);

    // Lowest eligible index wins; a zero code never counts as a request.
    always_comb begin
        elig      = '0;
        pick_oh   = '0;
        pick_code = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            elig[k] = i_req[k] && (i_code[k*COUNT_W +: COUNT_W] != '0);
            if (elig[k]) begin
                pick_oh    = '0;
                pick_oh[k] = 1'b1;
                pick_code  = i_code[k*COUNT_W +: COUNT_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        grant_d = grant_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            led_d   = 1'b0;
            grant_d = '0;
            if (i_enable && (|elig)) begin
                state_d = ST_ON;
                cnt_d   = pick_code;
                grant_d = pick_oh;
                led_d   = 1'b1;
            end
        end else if (!i_enable) begin
            state_d = ST_IDLE;
            led_d   = 1'b0;
            grant_d = '0;
        end else if (state_q != ST_GAP && !req_held) begin
            // Requester went away: finish with a normal gap so o_done still fires.
            state_d = ST_GAP;
            led_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ON: if (on_end) begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == COUNT_W'(1)) ? ST_GAP : ST_OFF;
                    led_d   = 1'b0;
                end
                ST_OFF: if (off_end) begin
                    state_d = ST_ON;
                    led_d   = 1'b1;
                end
                ST_GAP: if (gap_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    grant_d = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tick_q  <= '0;
            phase_q <= '0;
            led_q   <= 1'b0;
            grant_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            // Prescaler restarts on every state change so aborted phases stay exact too.
            if (state_d != state_q || state_q == ST_IDLE) begin
                tick_q  <= '0;
                phase_q <= '0;
            end else begin
                tick_q  <= tick ? '0 : tick_q + 1'b1;
                phase_q <= phase_q + PHASE_W'(tick);
            end
        end
    end

    assign o_led   = led_q;
    assign o_grant = grant_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = done_q;

endmodule
